// File: rtl/rf_wport_arbiter.sv
// rf_wport_arbiter
//   Shares the single integer register-file write port between the in-order
//   writeback stage and a long-latency unit (LLU). Results from the LLU land in
//   a one-entry skid buffer. The buffer drains whenever the pipe leaves the
//   port free. A starvation FSM holds the pipe after STARVE_LIMIT lost
//   arbitrations. A 32-entry busy scoreboard stalls decode on hazards against
//   outstanding LLU destinations.
//
// Ports
//   clock, reset                      clock; synchronous active-high reset
//   pipe_wen/pipe_rd/pipe_wdata       writeback-stage write request
//   llu_issue_valid/llu_issue_rd      LLU instruction issue (marks rd busy)
//   llu_res_valid/ready/rd/data       LLU result handshake
//   dec_rs1/dec_rs2/dec_rd/dec_rd_wen decode operands for hazard check
//   raw_stall                         decode must not issue
//   pipe_hold                         writeback must not present new writes
//   rf_wen/rf_waddr/rf_wdata          registered register-file write port
module rf_wport_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        pipe_wen,
    input  logic [4:0]  pipe_rd,
    input  logic [31:0] pipe_wdata,
    input  logic        llu_issue_valid,
    input  logic [4:0]  llu_issue_rd,
    input  logic        llu_res_valid,
    output logic        llu_res_ready,
    input  logic [4:0]  llu_res_rd,
    input  logic [31:0] llu_res_data,
    input  logic [4:0]  dec_rs1,
    input  logic [4:0]  dec_rs2,
    input  logic [4:0]  dec_rd,
    input  logic        dec_rd_wen,
    output logic        raw_stall,
    output logic        pipe_hold,
    output logic        rf_wen,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              buf_v_q, buf_v_d;
    logic [4:0]        buf_rd_q, buf_rd_d;
    logic [31:0]       buf_data_q, buf_data_d;
    logic [31:0]       busy_q, busy_d;
    logic              rf_wen_q, rf_wen_d;
    logic [4:0]        rf_waddr_q, rf_waddr_d;
    logic [31:0]       rf_wdata_q, rf_wdata_d;

    logic              pipe_req;
    logic              drain;
    logic              accept;
    logic [CNT_W-1:0]  cnt_inc;

    // A pipe write to x0 is treated as no request at all.
    assign pipe_req = pipe_wen && (pipe_rd != 5'd0);
    assign drain    = buf_v_q && !pipe_req;
    assign accept   = llu_res_valid && !buf_v_q;
    assign cnt_inc  = cnt_q + 1'b1;

    assign llu_res_ready = !buf_v_q;
    assign pipe_hold     = (state_q == DRAIN);
    assign raw_stall     = busy_q[dec_rs1] | busy_q[dec_rs2] |
                           (dec_rd_wen & busy_q[dec_rd]);

    assign rf_wen   = rf_wen_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

    // Write-port arbitration and skid buffer
    always_comb begin
        rf_wen_d   = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        buf_v_d    = buf_v_q;
        buf_rd_d   = buf_rd_q;
        buf_data_d = buf_data_q;

        if (pipe_req) begin
            rf_wen_d   = 1'b1;
            rf_waddr_d = pipe_rd;
            rf_wdata_d = pipe_wdata;
        end else if (buf_v_q) begin
            rf_wen_d   = 1'b1;
            rf_waddr_d = buf_rd_q;
            rf_wdata_d = buf_data_q;
            buf_v_d    = 1'b0;
        end

        // Acceptance and drain are mutually exclusive, because accept needs !buf_v_q.
        if (accept) begin
            buf_v_d    = 1'b1;
            buf_rd_d   = llu_res_rd;
            buf_data_d = llu_res_data;
        end
    end

    // Scoreboard: the clear is applied first so that a same-cycle set wins.
    always_comb begin
        busy_d = busy_q;
        if (drain) busy_d[buf_rd_q] = 1'b0;
        if (llu_issue_valid && (llu_issue_rd != 5'd0)) busy_d[llu_issue_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    // Starvation FSM
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (accept) state_d = PEND;
            end
            PEND: begin
                if (drain) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (pipe_req) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_W'(STARVE_LIMIT)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (drain) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            buf_v_q    <= 1'b0;
            buf_rd_q   <= '0;
            buf_data_q <= '0;
            busy_q     <= '0;
            rf_wen_q   <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            buf_v_q    <= buf_v_d;
            buf_rd_q   <= buf_rd_d;
            buf_data_q <= buf_data_d;
            busy_q     <= busy_d;
            rf_wen_q   <= rf_wen_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// tb_rf_wport_arbiter
//   Directed scenarios for rf_wport_arbiter with hand-computed expectations.
module tb_rf_wport_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        pipe_wen;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_wdata;
    logic        llu_issue_valid;
    logic [4:0]  llu_issue_rd;
    logic        llu_res_valid;
    logic        llu_res_ready;
    logic [4:0]  llu_res_rd;
    logic [31:0] llu_res_data;
    logic [4:0]  dec_rs1, dec_rs2, dec_rd;
    logic        dec_rd_wen;
    logic        raw_stall, pipe_hold, rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int vectors = 0;
    int miscompares = 0;

    rf_wport_arbiter #(.STARVE_LIMIT(4), .CNT_W(4)) dut (
        .clock(clock), .reset(reset),
        .pipe_wen(pipe_wen), .pipe_rd(pipe_rd), .pipe_wdata(pipe_wdata),
        .llu_issue_valid(llu_issue_valid), .llu_issue_rd(llu_issue_rd),
        .llu_res_valid(llu_res_valid), .llu_res_ready(llu_res_ready),
        .llu_res_rd(llu_res_rd), .llu_res_data(llu_res_data),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd), .dec_rd_wen(dec_rd_wen),
        .raw_stall(raw_stall), .pipe_hold(pipe_hold),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    always #5 clock = ~clock;

    // Writeback must never present a write while it is held.
    always @(negedge clock) begin
        if (!reset && pipe_hold && pipe_wen) begin
            miscompares++;
            $display("FAIL hold_violation: pipe_wen=1 while pipe_hold=1 at %0t", $time);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        pipe_wen = 0; pipe_rd = 0; pipe_wdata = 0;
        llu_issue_valid = 0; llu_issue_rd = 0;
        llu_res_valid = 0; llu_res_rd = 0; llu_res_data = 0;
        dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0; dec_rd_wen = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        tick(); tick();
        reset = 0;
        #1;
        vectors++; if (rf_wen !== 1'b0) begin miscompares++; $display("FAIL reset_rf_wen: got %b want 0", rf_wen); end
        vectors++; if (rf_waddr !== 5'd0) begin miscompares++; $display("FAIL reset_rf_waddr: got %0d want 0", rf_waddr); end
        vectors++; if (rf_wdata !== 32'd0) begin miscompares++; $display("FAIL reset_rf_wdata: got %h want 0", rf_wdata); end
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++; if (rf_wen !== 1'b0) begin miscompares++; $display("FAIL idle_rf_wen[%0d]: got %b want 0", i, rf_wen); end
            vectors++; if (llu_res_ready !== 1'b1) begin miscompares++; $display("FAIL idle_ready[%0d]: got %b want 1", i, llu_res_ready); end
            vectors++; if (raw_stall !== 1'b0) begin miscompares++; $display("FAIL idle_raw[%0d]: got %b want 0", i, raw_stall); end
            vectors++; if (pipe_hold !== 1'b0) begin miscompares++; $display("FAIL idle_hold[%0d]: got %b want 0", i, pipe_hold); end
        end
    endtask

    task automatic test_pipe_write();
        pipe_wen = 1; pipe_rd = 5; pipe_wdata = 32'h1234;
        tick();
        vectors++; if (rf_wen !== 1'b1) begin miscompares++; $display("FAIL pipe_wen: got %b want 1", rf_wen); end
        vectors++; if (rf_waddr !== 5'd5) begin miscompares++; $display("FAIL pipe_waddr: got %0d want 5", rf_waddr); end
        vectors++; if (rf_wdata !== 32'h1234) begin miscompares++; $display("FAIL pipe_wdata: got %h want 1234", rf_wdata); end
        pipe_rd = 0; pipe_wdata = 32'h9999;
        tick();
        vectors++; if (rf_wen !== 1'b0) begin miscompares++; $display("FAIL x0_wen: got %b want 0", rf_wen); end
        vectors++; if (rf_waddr !== 5'd5) begin miscompares++; $display("FAIL x0_waddr_hold: got %0d want 5", rf_waddr); end
        vectors++; if (rf_wdata !== 32'h1234) begin miscompares++; $display("FAIL x0_wdata_hold: got %h want 1234", rf_wdata); end
        idle_inputs();
    endtask

    task automatic test_llu_hazard();
        llu_issue_valid = 1; llu_issue_rd = 7;
        tick();
        llu_issue_valid = 0;
        dec_rs1 = 7;
        #1;
        vectors++; if (raw_stall !== 1'b1) begin miscompares++; $display("FAIL raw_rs1: got %b want 1", raw_stall); end
        dec_rs1 = 0; dec_rd = 7; dec_rd_wen = 0;
        #1;
        vectors++; if (raw_stall !== 1'b0) begin miscompares++; $display("FAIL raw_rd_nowen: got %b want 0", raw_stall); end
        dec_rd_wen = 1;
        #1;
        vectors++; if (raw_stall !== 1'b1) begin miscompares++; $display("FAIL waw_rd: got %b want 1", raw_stall); end
        dec_rd = 0; dec_rd_wen = 0; dec_rs2 = 7;
        llu_res_valid = 1; llu_res_rd = 7; llu_res_data = 32'hDEAD;
        #1;
        vectors++; if (llu_res_ready !== 1'b1) begin miscompares++; $display("FAIL llu_ready_before: got %b want 1", llu_res_ready); end
        tick();
        llu_res_valid = 0;
        #1;
        vectors++; if (llu_res_ready !== 1'b0) begin miscompares++; $display("FAIL llu_ready_buffered: got %b want 0", llu_res_ready); end
        vectors++; if (rf_wen !== 1'b0) begin miscompares++; $display("FAIL llu_early_write: got %b want 0", rf_wen); end
        vectors++; if (raw_stall !== 1'b1) begin miscompares++; $display("FAIL raw_rs2_buffered: got %b want 1", raw_stall); end
        tick();
        vectors++; if (rf_wen !== 1'b1) begin miscompares++; $display("FAIL llu_wen: got %b want 1", rf_wen); end
        vectors++; if (rf_waddr !== 5'd7) begin miscompares++; $display("FAIL llu_waddr: got %0d want 7", rf_waddr); end
        vectors++; if (rf_wdata !== 32'hDEAD) begin miscompares++; $display("FAIL llu_wdata: got %h want dead", rf_wdata); end
        vectors++; if (raw_stall !== 1'b0) begin miscompares++; $display("FAIL raw_cleared: got %b want 0", raw_stall); end
        vectors++; if (llu_res_ready !== 1'b1) begin miscompares++; $display("FAIL llu_ready_after: got %b want 1", llu_res_ready); end
        idle_inputs();
    endtask

    task automatic test_starvation();
        llu_issue_valid = 1; llu_issue_rd = 9;
        tick();
        llu_issue_valid = 0;
        llu_res_valid = 1; llu_res_rd = 9; llu_res_data = 32'hBEEF;
        pipe_wen = 1; pipe_rd = 10; pipe_wdata = 32'h100;
        tick();
        llu_res_valid = 0;
        for (int i = 1; i <= 4; i++) begin
            pipe_wdata = i;
            tick();
            vectors++; if (rf_waddr !== 5'd10 || rf_wdata !== 32'(i) || rf_wen !== 1'b1)
                begin miscompares++; $display("FAIL starve_pipe[%0d]: got wen=%b addr=%0d data=%h want 1/10/%h", i, rf_wen, rf_waddr, rf_wdata, i); end
            vectors++; if (llu_res_ready !== 1'b0) begin miscompares++; $display("FAIL starve_ready[%0d]: got %b want 0", i, llu_res_ready); end
            vectors++; if (pipe_hold !== (i == 4)) begin miscompares++; $display("FAIL starve_hold[%0d]: got %b want %b", i, pipe_hold, (i == 4)); end
            if (i == 4) pipe_wen = 0;
        end
        #1;
        vectors++; if (pipe_hold !== 1'b1) begin miscompares++; $display("FAIL hold_persist: got %b want 1", pipe_hold); end
        tick();
        vectors++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'hBEEF)
            begin miscompares++; $display("FAIL starve_drain: got wen=%b addr=%0d data=%h want 1/9/beef", rf_wen, rf_waddr, rf_wdata); end
        vectors++; if (pipe_hold !== 1'b0) begin miscompares++; $display("FAIL hold_release: got %b want 0", pipe_hold); end
        vectors++; if (llu_res_ready !== 1'b1) begin miscompares++; $display("FAIL starve_ready_after: got %b want 1", llu_res_ready); end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        llu_res_valid = 1; llu_res_rd = 11; llu_res_data = 32'hA1;
        tick();
        llu_res_rd = 12; llu_res_data = 32'hB2;
        #1;
        vectors++; if (llu_res_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_ready_full: got %b want 0", llu_res_ready); end
        tick();
        vectors++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd11 || rf_wdata !== 32'hA1)
            begin miscompares++; $display("FAIL b2b_first: got wen=%b addr=%0d data=%h want 1/11/a1", rf_wen, rf_waddr, rf_wdata); end
        vectors++; if (llu_res_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready_free: got %b want 1", llu_res_ready); end
        tick();
        llu_res_valid = 0;
        #1;
        vectors++; if (rf_wen !== 1'b0) begin miscompares++; $display("FAIL b2b_gap: got %b want 0", rf_wen); end
        vectors++; if (llu_res_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_ready_second: got %b want 0", llu_res_ready); end
        tick();
        vectors++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd12 || rf_wdata !== 32'hB2)
            begin miscompares++; $display("FAIL b2b_second: got wen=%b addr=%0d data=%h want 1/12/b2", rf_wen, rf_waddr, rf_wdata); end
        tick();
        vectors++; if (rf_wen !== 1'b0) begin miscompares++; $display("FAIL b2b_no_dup: got %b want 0", rf_wen); end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        llu_issue_valid = 1; llu_issue_rd = 3;
        tick();
        llu_issue_valid = 0;
        llu_res_valid = 1; llu_res_rd = 3; llu_res_data = 32'h33;
        tick();
        llu_res_valid = 0;
        dec_rs1 = 3;
        #1;
        vectors++; if (llu_res_ready !== 1'b0 || raw_stall !== 1'b1)
            begin miscompares++; $display("FAIL mid_pre: got ready=%b raw=%b want 0/1", llu_res_ready, raw_stall); end
        reset = 1;
        tick();
        reset = 0;
        #1;
        vectors++; if (llu_res_ready !== 1'b1) begin miscompares++; $display("FAIL mid_ready: got %b want 1", llu_res_ready); end
        vectors++; if (raw_stall !== 1'b0) begin miscompares++; $display("FAIL mid_raw: got %b want 0", raw_stall); end
        vectors++; if (rf_wen !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0)
            begin miscompares++; $display("FAIL mid_rf: got wen=%b addr=%0d data=%h want 0/0/0", rf_wen, rf_waddr, rf_wdata); end
        tick();
        vectors++; if (rf_wen !== 1'b0) begin miscompares++; $display("FAIL mid_spurious: got %b want 0", rf_wen); end
        vectors++; if (raw_stall !== 1'b0) begin miscompares++; $display("FAIL mid_raw_after: got %b want 0", raw_stall); end
        idle_inputs();
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        test_reset();
        test_pipe_write();
        test_llu_hazard();
        test_starvation();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/rf_wport_arbiter.md
Name: rf_wport_arbiter

Overview:
- Arbitrates the single integer register-file write port between two sources:
  - the in-order writeback stage, which writes every cycle it has a result;
  - a long-latency unit (LLU), such as a multi-cycle divider, which returns results out of order over a valid/ready handshake.
- Holds a 32-entry busy scoreboard so decode stalls on RAW/WAW hazards against outstanding LLU results.
- Prevents LLU starvation by holding the pipeline when needed.
- Sits between the writeback stage, the LLU and the register file.

Parameters:
- STARVE_LIMIT, 4: consecutive cycles a buffered LLU result may lose arbitration before the pipeline is held (1..15).
- CNT_W, 4: width of the starvation counter.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- pipe_wen  in  1  writeback stage has a register write this cycle
- pipe_rd  in  5  writeback destination
- pipe_wdata  in  32  writeback data
- llu_issue_valid  in  1  an instruction targeting the LLU issues this cycle
- llu_issue_rd  in  5  destination of the issued LLU instruction
- llu_res_valid  in  1  LLU result available
- llu_res_ready  out  1  arbiter accepts the LLU result
- llu_res_rd  in  5  LLU result destination
- llu_res_data  in  32  LLU result data
- dec_rs1  in  5  decode source register 1
- dec_rs2  in  5  decode source register 2
- dec_rd  in  5  decode destination register
- dec_rd_wen  in  1  decode instruction writes dec_rd
- raw_stall  out  1  decode must not issue
- pipe_hold  out  1  writeback stage must not present new writes
- rf_wen  out  1  register-file write enable (registered)
- rf_waddr  out  5  register-file write address (registered)
- rf_wdata  out  32  register-file write data (registered)

Behaviour:
- Clock and reset: reset is synchronous, active-high; clock is clock. All state updates on posedge clock.
- Reset values:
  - rf_wen = 0, rf_waddr = 0, rf_wdata = 0.
  - buffer empty; busy[31:0] = 0; counter = 0; state = IDLE.
  - Consequently llu_res_ready = 1, pipe_hold = 0, raw_stall = 0.
- Reset mid-operation discards any buffered LLU result and all busy bits. The LLU must be reset in the same cycle.

Skid buffer (1 entry: buf_v, buf_rd, buf_data):
- llu_res_ready = !buf_v. This is combinational and does not depend on llu_res_valid.
- Handshake: llu_res_valid && llu_res_ready loads the buffer at the clock edge.
- A buffered result is eligible for the write port from the next cycle onward.

Arbitration (each cycle; result registered onto rf_* at the edge, one-cycle latency):
- pipe_wen=1 and pipe_rd!=0: the pipe wins. rf_wen=1, rf_waddr=pipe_rd, rf_wdata=pipe_wdata.
- Otherwise, buf_v=1: the buffer wins. It writes buf_rd/buf_data, buf_v clears, and busy[buf_rd] clears.
- Otherwise: rf_wen=0. rf_waddr and rf_wdata hold their previous values.
- Writes to x0 are never issued. pipe_wen with pipe_rd=0 counts as no request.
- A buffer drain and a new LLU acceptance may not occur in the same cycle (ready is low while buf_v=1).

Starvation FSM:
- IDLE: buffer empty, counter = 0. Go to PEND when the buffer loads.
- PEND: counter increments each cycle the pipe wins while buf_v=1.
  - Buffer drains: return to IDLE, counter = 0.
  - Counter reaches STARVE_LIMIT: go to DRAIN.
- DRAIN: pipe_hold = 1, driven combinationally from the state. The buffer wins the next cycle, because upstream presents pipe_wen=0 while held.
  - After the drain: IDLE, counter = 0.
  - If pipe_wen=1 arrives anyway during DRAIN, the pipe still wins and the state remains DRAIN. This is a protocol violation and the bench flags it.

Scoreboard:
- Set: busy[llu_issue_rd] is set at the edge when llu_issue_valid=1 and llu_issue_rd!=0. busy[0] is always 0.
- Clear: by a buffer drain to that register.
- Simultaneous set and clear of the same register: set wins.
- raw_stall = busy[dec_rs1] | busy[dec_rs2] | (dec_rd_wen & busy[dec_rd]). Combinational.
- Decode does not issue while raw_stall=1. Therefore no pipe write ever targets a busy register.

Test Plan:
- Reset then idle: after reset, rf_wen=0, llu_res_ready=1, raw_stall=0, pipe_hold=0 → all held across 5 idle cycles.
- Pipe-only write: pipe_wen=1, rd=5, data=0x1234 → next cycle rf_wen=1, waddr=5, wdata=0x1234. A pipe write with rd=0 → rf_wen=0.
- LLU issue, hazard and return:
  - issue rd=7; decode rs1=7 → raw_stall=1.
  - LLU returns rd=7, data=0xDEAD with pipe idle → accepted, written two cycles after valid.
  - busy[7] clears and raw_stall drops the cycle after the write.
- Contention and starvation (STARVE_LIMIT=4):
  - LLU result buffered while pipe_wen=1 continuously → pipe writes for 4 cycles, then pipe_hold=1.
  - Bench drops pipe_wen → buffered result written, pipe_hold=0 the following cycle.
  - llu_res_ready stays 0 throughout the buffered period.
- Back-to-back LLU results: second llu_res_valid held while the buffer is full → llu_res_ready=0 until the drain. Second result is written the cycle after it is accepted, with no loss.
- Reset mid-operation: buffer full and busy[3]=1; assert reset for one cycle → buffer empty, raw_stall=0 for rs1=3, no spurious rf write.
